// File: rtl/decision_unit_top2.sv
// Argmax stage closing the CNN classifier: scans NUM_CLASSES scores from a
// fixed-latency result memory and reports winner, runner-up, top score and margin.
module decision_unit_top2 #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned RD_LATENCY  = 1,
  parameter bit          SIGNED      = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   threshold,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_en,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    category_out,
  output logic [IDX_W-1:0]    runner_up_out,
  output logic [DATA_W-1:0]   max_score,
  output logic [DATA_W:0]     margin,
  output logic                low_conf
);

  localparam int unsigned MARGIN_W = DATA_W + 1;
  localparam int unsigned CNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  if (NUM_CLASSES < 2) begin : g_bad_classes
    $error("decision_unit_top2: NUM_CLASSES must be >= 2");
  end
  if ((64'(1) << IDX_W) < 64'(NUM_CLASSES)) begin : g_bad_idx
    $error("decision_unit_top2: IDX_W too narrow for NUM_CLASSES");
  end
  if (RD_LATENCY < 1) begin : g_bad_lat
    $error("decision_unit_top2: RD_LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    else        return a > b;
  endfunction

  function automatic logic [MARGIN_W-1:0] ext(input logic [DATA_W-1:0] a);
    if (SIGNED) return {a[DATA_W-1], a};
    else        return {1'b0, a};
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     thr_q, thr_d;
  logic [RD_LATENCY-1:0] pipe_v_q, pipe_v_d;
  logic [IDX_W-1:0]      pipe_i_q [RD_LATENCY];
  logic [IDX_W-1:0]      pipe_i_d [RD_LATENCY];
  logic [DATA_W-1:0]     best_s_q, best_s_d, run_s_q, run_s_d;
  logic [IDX_W-1:0]      best_i_q, best_i_d, run_i_q, run_i_d;
  logic                  best_v_q, best_v_d, run_v_q, run_v_d;
  logic [IDX_W-1:0]      category_q, category_d, runner_q, runner_d;
  logic [DATA_W-1:0]     max_q, max_d;
  logic [MARGIN_W-1:0]   margin_q, margin_d;
  logic                  low_conf_q, low_conf_d;

  logic                  cons_v_c;
  logic [IDX_W-1:0]      cons_i_c;
  logic [MARGIN_W-1:0]   margin_c;

  assign cons_v_c = pipe_v_q[RD_LATENCY-1];
  assign cons_i_c = pipe_i_q[RD_LATENCY-1];
  assign margin_c = ext(best_s_q) - ext(run_s_q);

  // Next-state, request issue, index pipeline and running best/runner-up tracking
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = '0;
    rd_en_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    thr_d      = thr_q;
    best_s_d   = best_s_q;
    best_i_d   = best_i_q;
    best_v_d   = best_v_q;
    run_s_d    = run_s_q;
    run_i_d    = run_i_q;
    run_v_d    = run_v_q;
    category_d = category_q;
    runner_d   = runner_q;
    max_d      = max_q;
    margin_d   = margin_q;
    low_conf_d = low_conf_q;

    pipe_v_d[0] = rd_en_q;
    pipe_i_d[0] = IDX_W'(rd_addr_q);
    for (int k = 1; k < int'(RD_LATENCY); k++) begin
      pipe_v_d[k] = pipe_v_q[k-1];
      pipe_i_d[k] = pipe_i_q[k-1];
    end

    // Strict compares: ties keep the earlier index as best
    if (cons_v_c) begin
      if (!best_v_q) begin
        best_s_d = rd_data;
        best_i_d = cons_i_c;
        best_v_d = 1'b1;
        run_v_d  = 1'b0;
      end else if (gt(rd_data, best_s_q)) begin
        run_s_d  = best_s_q;
        run_i_d  = best_i_q;
        run_v_d  = 1'b1;
        best_s_d = rd_data;
        best_i_d = cons_i_c;
      end else if (!run_v_q || gt(rd_data, run_s_q)) begin
        run_s_d  = rd_data;
        run_i_d  = cons_i_c;
        run_v_d  = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        busy_d = start;
        if (start) begin
          thr_d    = threshold;
          best_v_d = 1'b0;
          run_v_d  = 1'b0;
          rd_en_d  = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rd_addr_q == ADDR_W'(NUM_CLASSES - 1)) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(RD_LATENCY - 1)) state_d = ST_DONE;
        else                                 cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_DONE: begin
        category_d = best_i_q;
        runner_d   = run_i_q;
        max_d      = best_s_q;
        margin_d   = margin_c;
        low_conf_d = margin_c < {1'b0, thr_q};
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      thr_q      <= '0;
      pipe_v_q   <= '0;
      for (int k = 0; k < int'(RD_LATENCY); k++) pipe_i_q[k] <= '0;
      best_s_q   <= '0;
      best_i_q   <= '0;
      best_v_q   <= 1'b0;
      run_s_q    <= '0;
      run_i_q    <= '0;
      run_v_q    <= 1'b0;
      category_q <= '0;
      runner_q   <= '0;
      max_q      <= '0;
      margin_q   <= '0;
      low_conf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      thr_q      <= thr_d;
      pipe_v_q   <= pipe_v_d;
      for (int k = 0; k < int'(RD_LATENCY); k++) pipe_i_q[k] <= pipe_i_d[k];
      best_s_q   <= best_s_d;
      best_i_q   <= best_i_d;
      best_v_q   <= best_v_d;
      run_s_q    <= run_s_d;
      run_i_q    <= run_i_d;
      run_v_q    <= run_v_d;
      category_q <= category_d;
      runner_q   <= runner_d;
      max_q      <= max_d;
      margin_q   <= margin_d;
      low_conf_q <= low_conf_d;
    end
  end

  assign rd_addr       = rd_addr_q;
  assign rd_en         = rd_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign category_out  = category_q;
  assign runner_up_out = runner_q;
  assign max_score     = max_q;
  assign margin        = margin_q;
  assign low_conf      = low_conf_q;

endmodule

// File: tb/tb_decision_unit_top2.sv
// Directed bench for decision_unit_top2: default, signed and 16-class/latency-3 instances.
module tb_decision_unit_top2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2:0]        start_v = '0;
  logic [7:0]        thr = '0;
  logic [2:0][9:0]   addr_w;
  logic [2:0]        en_w, busy_w, done_w, low_w;
  logic [2:0][7:0]   rdat_w, max_w;
  logic [2:0][3:0]   cat_w, run_w;
  logic [2:0][8:0]   mar_w;
  logic [7:0]        mem [3][16];
  logic [7:0]        p1, p2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  decision_unit_top2 u_def (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .threshold(thr),
    .rd_addr(addr_w[0]), .rd_en(en_w[0]), .rd_data(rdat_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .category_out(cat_w[0]),
    .runner_up_out(run_w[0]), .max_score(max_w[0]), .margin(mar_w[0]),
    .low_conf(low_w[0]));

  decision_unit_top2 #(.SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .threshold(thr),
    .rd_addr(addr_w[1]), .rd_en(en_w[1]), .rd_data(rdat_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .category_out(cat_w[1]),
    .runner_up_out(run_w[1]), .max_score(max_w[1]), .margin(mar_w[1]),
    .low_conf(low_w[1]));

  decision_unit_top2 #(.NUM_CLASSES(16), .RD_LATENCY(3)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .threshold(thr),
    .rd_addr(addr_w[2]), .rd_en(en_w[2]), .rd_data(rdat_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .category_out(cat_w[2]),
    .runner_up_out(run_w[2]), .max_score(max_w[2]), .margin(mar_w[2]),
    .low_conf(low_w[2]));

  // Score memories: latency 1 for the first two instances, 3 for the third
  always @(posedge clk) begin
    rdat_w[0] <= mem[0][addr_w[0][3:0]];
    rdat_w[1] <= mem[1][addr_w[1][3:0]];
    p1        <= mem[2][addr_w[2][3:0]];
    p2        <= p1;
    rdat_w[2] <= p2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int k, input logic [7:0] v);
    for (int i = 0; i < 16; i++) mem[k][i] = v;
  endtask

  // Pulse start on instance k and follow the scan until done (bounded)
  task automatic run_scan(input int k, input logic [7:0] t, input int inj,
                          output int lat, output int en_cnt, output bit addr_ok);
    int exp_a;
    @(negedge clk);
    thr = t;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    lat = 0; en_cnt = 0; exp_a = 0; addr_ok = 1'b1;
    if (en_w[k]) begin
      if (addr_w[k] != 10'(exp_a)) addr_ok = 1'b0;
      exp_a++; en_cnt++;
    end
    while (!done_w[k] && lat < 100) begin
      start_v[k] = (lat == inj);
      @(posedge clk); #1;
      lat++;
      if (en_w[k]) begin
        if (addr_w[k] != 10'(exp_a)) addr_ok = 1'b0;
        exp_a++; en_cnt++;
      end else if (addr_w[k] != 10'd0) addr_ok = 1'b0;
    end
    start_v[k] = 1'b0;
  endtask

  // Checks the one-cycle done pulse and busy falling with it
  task automatic chk_pulse(input int k, input string tag);
    chk({tag, "_busy_at_done"}, 32'(busy_w[k]), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_done_fall"}, 32'(done_w[k]), 32'd0);
    chk({tag, "_busy_fall"}, 32'(busy_w[k]), 32'd0);
  endtask

  initial begin
    int  lat, en_cnt;
    bit  addr_ok, saw_done;

    for (int k = 0; k < 3; k++) fill(k, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy_w[0]), 32'd0);
    chk("rst_done",  32'(done_w[0]), 32'd0);
    chk("rst_rd_en", 32'(en_w[0]),   32'd0);
    chk("rst_addr",  32'(addr_w[0]), 32'd0);
    chk("rst_cat",   32'(cat_w[0]),  32'd0);
    chk("rst_margin", 32'(mar_w[0]), 32'd0);
    chk("rst_low",   32'(low_w[0]),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: clear winner at 7, runner-up at 3
    fill(0, 8'd10); mem[0][3] = 8'd150; mem[0][7] = 8'd200;
    run_scan(0, 8'd20, -1, lat, en_cnt, addr_ok);
    chk("s1_latency", 32'(lat), 32'd12);
    chk("s1_rd_en_cycles", 32'(en_cnt), 32'd10);
    chk("s1_addr_seq", 32'(addr_ok), 32'd1);
    chk("s1_cat", 32'(cat_w[0]), 32'd7);
    chk("s1_runner", 32'(run_w[0]), 32'd3);
    chk("s1_max", 32'(max_w[0]), 32'd200);
    chk("s1_margin", 32'(mar_w[0]), 32'd50);
    chk("s1_low", 32'(low_w[0]), 32'd0);
    chk_pulse(0, "s1");

    // Scenario 2: tie keeps lower index, later equal becomes runner-up
    fill(0, 8'd10); mem[0][2] = 8'd90; mem[0][5] = 8'd90;
    run_scan(0, 8'd1, -1, lat, en_cnt, addr_ok);
    chk("s2_cat", 32'(cat_w[0]), 32'd2);
    chk("s2_runner", 32'(run_w[0]), 32'd5);
    chk("s2_margin", 32'(mar_w[0]), 32'd0);
    chk("s2_low", 32'(low_w[0]), 32'd1);

    // Scenario 3: same scores, unsigned and signed interpretation
    fill(0, 8'hF0); mem[0][4] = 8'h05; mem[0][8] = 8'hFE;
    fill(1, 8'hF0); mem[1][4] = 8'h05; mem[1][8] = 8'hFE;
    run_scan(0, 8'd20, -1, lat, en_cnt, addr_ok);
    chk("s3u_cat", 32'(cat_w[0]), 32'd8);
    chk("s3u_runner", 32'(run_w[0]), 32'd0);
    chk("s3u_margin", 32'(mar_w[0]), 32'd14);
    chk("s3u_low", 32'(low_w[0]), 32'd1);
    run_scan(1, 8'd20, -1, lat, en_cnt, addr_ok);
    chk("s3s_latency", 32'(lat), 32'd12);
    chk("s3s_cat", 32'(cat_w[1]), 32'd4);
    chk("s3s_runner", 32'(run_w[1]), 32'd8);
    chk("s3s_max", 32'(max_w[1]), 32'h05);
    chk("s3s_margin", 32'(mar_w[1]), 32'd7);

    // Scenario 4: 16 classes, latency 3, ascending scores
    for (int i = 0; i < 16; i++) mem[2][i] = 8'(i);
    run_scan(2, 8'd0, -1, lat, en_cnt, addr_ok);
    chk("s4_latency", 32'(lat), 32'd20);
    chk("s4_rd_en_cycles", 32'(en_cnt), 32'd16);
    chk("s4_addr_seq", 32'(addr_ok), 32'd1);
    chk("s4_cat", 32'(cat_w[2]), 32'd15);
    chk("s4_runner", 32'(run_w[2]), 32'd14);
    chk("s4_max", 32'(max_w[2]), 32'd15);
    chk("s4_margin", 32'(mar_w[2]), 32'd1);
    chk("s4_low", 32'(low_w[2]), 32'd0);
    chk_pulse(2, "s4");

    // Scenario 5: descending scores, stray start mid-scan is ignored
    for (int i = 0; i < 10; i++) mem[0][i] = 8'(9 - i);
    run_scan(0, 8'd1, 4, lat, en_cnt, addr_ok);
    chk("s5_latency", 32'(lat), 32'd12);
    chk("s5_rd_en_cycles", 32'(en_cnt), 32'd10);
    chk("s5_addr_seq", 32'(addr_ok), 32'd1);
    chk("s5_cat", 32'(cat_w[0]), 32'd0);
    chk("s5_runner", 32'(run_w[0]), 32'd1);
    chk("s5_margin", 32'(mar_w[0]), 32'd1);
    chk("s5_low", 32'(low_w[0]), 32'd0);
    chk_pulse(0, "s5");

    // Scenario 6: reset mid-scan aborts, then a fresh run repeats scenario 1
    fill(0, 8'd10); mem[0][3] = 8'd150; mem[0][7] = 8'd200;
    @(negedge clk);
    thr = 8'd20;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_busy", 32'(busy_w[0]), 32'd0);
    chk("s6_rd_en", 32'(en_w[0]), 32'd0);
    chk("s6_addr", 32'(addr_w[0]), 32'd0);
    chk("s6_cat", 32'(cat_w[0]), 32'd0);
    chk("s6_runner", 32'(run_w[0]), 32'd0);
    chk("s6_max", 32'(max_w[0]), 32'd0);
    chk("s6_margin", 32'(mar_w[0]), 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_w[0]) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      if (done_w[0]) saw_done = 1'b1;
    end
    chk("s6_no_done", 32'(saw_done), 32'd0);
    chk("s6_idle_busy", 32'(busy_w[0]), 32'd0);
    run_scan(0, 8'd20, -1, lat, en_cnt, addr_ok);
    chk("s6_latency", 32'(lat), 32'd12);
    chk("s6_rerun_cat", 32'(cat_w[0]), 32'd7);
    chk("s6_rerun_runner", 32'(run_w[0]), 32'd3);
    chk("s6_rerun_max", 32'(max_w[0]), 32'd200);
    chk("s6_rerun_margin", 32'(mar_w[0]), 32'd50);
    chk("s6_rerun_low", 32'(low_w[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
